// File: rtl/kb_typematic_fifo.sv
// Keyboard event front-end: turns kb_driver's level-style key outputs into make/repeat
// events and queues them in a first-word-fall-through FIFO for the CPU to pop.
module kb_typematic_fifo #(
   parameter int unsigned DELAY_CYC = 25000000,
   parameter int unsigned RATE_CYC  = 5000000,
   parameter int unsigned DEPTH     = 16
) (
   input  logic                     CLOCK_50,
   input  logic                     rst,
   input  logic [7:0]               key_ascii_i,
   input  logic [4:0]               key_flags_i,
   input  logic                     repeat_en_i,
   input  logic                     rd_en_i,
   input  logic                     clr_ovf_i,
   output logic [15:0]              rd_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned TMAX = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
   localparam int unsigned TW   = $clog2(TMAX) + 1;

   localparam logic [TW-1:0] DELAY_LAST = TW'(DELAY_CYC - 1);
   localparam logic [TW-1:0] RATE_LAST  = TW'(RATE_CYC - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   typedef struct packed {
      logic       is_repeat;
      logic [1:0] rsvd;
      logic [4:0] flags;
      logic [7:0] ascii;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REPEAT
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [7:0]      prev_ascii_q;

   logic            push_c;
   logic            push_rep_c;
   entry_t          entry_c;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   remain_c;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            overflow_q, overflow_d;
   entry_t          rd_data_q, rd_data_d;

   logic            key_held_c;
   logic            rollover_c;
   logic            pop_c;
   logic            wr_c;
   logic            drop_c;

   assign key_held_c = (key_ascii_i != 8'h00);
   assign rollover_c = key_held_c && (key_ascii_i != prev_ascii_q);

   // Typematic state register
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         prev_ascii_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         prev_ascii_q <= key_ascii_i;
      end
   end

   // Typematic next-state: make on new key, repeat after DELAY then every RATE
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      push_c     = 1'b0;
      push_rep_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (key_held_c) begin
               push_c  = 1'b1;
               state_d = S_HOLD;
               timer_d = '0;
            end
         end
         S_HOLD: begin
            if (!key_held_c) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else if (rollover_c) begin
               push_c  = 1'b1;
               timer_d = '0;
            end else if (timer_q == DELAY_LAST) begin
               // Saturates here while repeat is disabled, so the push fires once re-enabled
               if (repeat_en_i) begin
                  push_c     = 1'b1;
                  push_rep_c = 1'b1;
                  state_d    = S_REPEAT;
                  timer_d    = '0;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_REPEAT: begin
            if (!key_held_c) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else if (rollover_c) begin
               push_c  = 1'b1;
               state_d = S_HOLD;
               timer_d = '0;
            end else if (repeat_en_i) begin
               if (timer_q == RATE_LAST) begin
                  push_c     = 1'b1;
                  push_rep_c = 1'b1;
                  timer_d    = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      entry_c           = '0;
      entry_c.is_repeat = push_rep_c;
      entry_c.flags     = key_flags_i;
      entry_c.ascii     = key_ascii_i;
   end

   // FIFO bookkeeping; a pop frees a slot for a same-cycle push even when full
   always_comb begin
      pop_c    = rd_en_i && !empty_q;
      wr_c     = push_c && (!full_q || pop_c);
      drop_c   = push_c && full_q && !pop_c;
      rd_ptr_d = pop_c ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      wr_ptr_d = wr_c  ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      count_d  = count_q + CW'(wr_c) - CW'(pop_c);
      remain_c = count_q - CW'(pop_c);
      empty_d  = (count_d == '0);
      full_d   = (count_d == COUNT_FULL);

      overflow_d = overflow_q;
      if (drop_c) begin
         overflow_d = 1'b1;
      end else if (clr_ovf_i) begin
         overflow_d = 1'b0;
      end

      // Head after this edge: the incoming entry if nothing older survives the pop
      rd_data_d = '0;
      if (remain_c == '0) begin
         if (wr_c) begin
            rd_data_d = entry_c;
         end
      end else begin
         rd_data_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage needs no reset: stale slots are never visible past the pointers
   always_ff @(posedge CLOCK_50) begin
      if (!rst && wr_c) begin
         mem_q[wr_ptr_q] <= entry_c;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign empty_o    = empty_q;
   assign full_o     = full_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_kb_typematic_fifo.sv
// Bench for kb_typematic_fifo: queue-based event model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_kb_typematic_fifo;

   localparam int unsigned DELAY = 10;
   localparam int unsigned RATE  = 4;
   localparam int unsigned DEPTH = 4;

   logic        CLOCK_50;
   logic        rst;
   logic [7:0]  key_ascii;
   logic [4:0]  key_flags;
   logic        repeat_en;
   logic        rd_en;
   logic        clr_ovf;
   logic [15:0] rd_data;
   logic        empty;
   logic        full;
   logic [2:0]  count;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   kb_typematic_fifo #(
      .DELAY_CYC(DELAY),
      .RATE_CYC (RATE),
      .DEPTH    (DEPTH)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .rst        (rst),
      .key_ascii_i(key_ascii),
      .key_flags_i(key_flags),
      .repeat_en_i(repeat_en),
      .rd_en_i    (rd_en),
      .clr_ovf_i  (clr_ovf),
      .rd_data_o  (rd_data),
      .empty_o    (empty),
      .full_o     (full),
      .count_o    (count),
      .overflow_o (overflow)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: events from key history (time since last event vs due time), FIFO as a queue
   logic [15:0] mq[$];
   bit          m_live = 0;
   bit          m_ovf;
   logic [7:0]  m_prev;
   int          m_elapsed;
   int          m_due;

   always @(posedge CLOCK_50) begin
      bit          ev;
      bit          drop;
      logic [15:0] evd;
      if (rst) begin
         mq.delete();
         m_ovf     = 0;
         m_prev    = 8'h00;
         m_elapsed = 0;
         m_due     = DELAY;
         m_live    = 1;
      end else begin
         ev  = 0;
         evd = 16'h0000;
         if (key_ascii != 8'h00 && key_ascii != m_prev) begin
            ev        = 1;
            evd       = {1'b0, 2'b00, key_flags, key_ascii};
            m_elapsed = 0;
            m_due     = DELAY;
         end else if (key_ascii != 8'h00) begin
            if (m_elapsed < m_due) m_elapsed++;
            if (m_elapsed >= m_due && repeat_en) begin
               ev        = 1;
               evd       = {1'b1, 2'b00, key_flags, key_ascii};
               m_elapsed = 0;
               m_due     = RATE;
            end
         end
         m_prev = key_ascii;
         if (rd_en && mq.size() > 0) void'(mq.pop_front());
         drop = 0;
         if (ev) begin
            if (mq.size() < DEPTH) mq.push_back(evd);
            else drop = 1;
         end
         if (drop) m_ovf = 1;
         else if (clr_ovf) m_ovf = 0;
      end
   end

   always @(negedge CLOCK_50) begin
      logic [15:0] head;
      if (m_live) begin
         head = (mq.size() > 0) ? mq[0] : 16'h0000;
         chk("m_rd_data",  32'(rd_data),  32'(head));
         chk("m_empty",    32'(empty),    32'(mq.size() == 0));
         chk("m_full",     32'(full),     32'(mq.size() == DEPTH));
         chk("m_count",    32'(count),    32'(mq.size()));
         chk("m_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; key_ascii = 8'h00; key_flags = 5'b0; repeat_en = 1'b1;
      rd_en = 1'b0; clr_ovf = 1'b0;

      // 1: reset
      cyc(2);
      chk("t1_empty",    32'(empty),    32'd1);
      chk("t1_full",     32'(full),     32'd0);
      chk("t1_count",    32'(count),    32'd0);
      chk("t1_overflow", 32'(overflow), 32'd0);
      chk("t1_rd_data",  32'(rd_data),  32'h0000);
      rst = 1'b0;
      cyc(1);

      // 2: single make, then pop (plus ignored pop on empty)
      key_ascii = 8'h41; key_flags = 5'b00001;
      cyc(1);
      chk("t2_empty",   32'(empty),   32'd0);
      chk("t2_rd_data", 32'(rd_data), 32'h0141);
      cyc(2);
      key_ascii = 8'h00; key_flags = 5'b0;
      cyc(1);
      chk("t2_count", 32'(count), 32'd1);
      pop1();
      chk("t2_empty_pop", 32'(empty), 32'd1);
      pop1();
      chk("t2_count_nop", 32'(count), 32'd0);

      // 3: held key with repeats at 0, 10, 14, 18
      key_ascii = 8'h61;
      cyc(1);
      chk("t3_c0",   32'(count),   32'd1);
      chk("t3_rd0",  32'(rd_data), 32'h0061);
      cyc(9);
      chk("t3_c9",   32'(count),   32'd1);
      cyc(1);
      chk("t3_c10",  32'(count),   32'd2);
      cyc(4);
      chk("t3_c14",  32'(count),   32'd3);
      cyc(4);
      chk("t3_c18",  32'(count),   32'd4);
      chk("t3_full", 32'(full),    32'd1);
      chk("t3_mq0",  32'(mq[0]),   32'h0061);
      chk("t3_mq1",  32'(mq[1]),   32'h8061);
      chk("t3_mq3",  32'(mq[3]),   32'h8061);
      cyc(3);
      chk("t3_ovf21", 32'(overflow), 32'd0);

      // 4: drop at cycle 22, clear, then pop+push while full at cycle 26
      cyc(1);
      chk("t4_ovf22", 32'(overflow), 32'd1);
      chk("t4_c22",   32'(count),    32'd4);
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      chk("t4_clr", 32'(overflow), 32'd0);
      cyc(2);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      chk("t4_pp_count", 32'(count),    32'd4);
      chk("t4_pp_ovf",   32'(overflow), 32'd0);
      chk("t4_pp_head",  32'(rd_data),  32'h8061);
      key_ascii = 8'h00;
      rd_en = 1'b1;
      cyc(6);
      rd_en = 1'b0;
      chk("t4_drain", 32'(empty), 32'd1);

      // 5: rollover with repeat enabled
      key_ascii = 8'h61;
      cyc(5);
      key_ascii = 8'h62;
      cyc(1);
      chk("t5_c5",  32'(count), 32'd2);
      cyc(9);
      chk("t5_c14", 32'(count), 32'd2);
      cyc(1);
      chk("t5_c15", 32'(count), 32'd3);
      key_ascii = 8'h00;
      cyc(1);
      chk("t5_e0", 32'(rd_data), 32'h0061);
      pop1();
      chk("t5_e1", 32'(rd_data), 32'h0062);
      pop1();
      chk("t5_e2", 32'(rd_data), 32'h8062);
      pop1();
      chk("t5_e3", 32'(empty), 32'd1);

      // 5b: rollover with repeat disabled, then re-enable fires the pending repeat
      repeat_en = 1'b0;
      key_ascii = 8'h61;
      cyc(5);
      key_ascii = 8'h62;
      cyc(20);
      chk("t5b_count", 32'(count), 32'd2);
      repeat_en = 1'b1;
      cyc(1);
      chk("t5b_pend", 32'(count), 32'd3);
      key_ascii = 8'h00;
      cyc(1);
      rd_en = 1'b1;
      cyc(4);
      rd_en = 1'b0;
      chk("t5b_drain", 32'(empty), 32'd1);

      // 6: reset during REPEAT with count=3; held key makes fresh entry
      key_ascii = 8'h61; key_flags = 5'b00110;
      cyc(15);
      chk("t6_c3", 32'(count), 32'd3);
      rst = 1'b1;
      cyc(1);
      chk("t6_rst_count", 32'(count),   32'd0);
      chk("t6_rst_empty", 32'(empty),   32'd1);
      chk("t6_rst_rd",    32'(rd_data), 32'h0000);
      rst = 1'b0;
      cyc(1);
      chk("t6_make_count", 32'(count),   32'd1);
      chk("t6_make_rd",    32'(rd_data), 32'h0661);
      key_ascii = 8'h00; key_flags = 5'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
